// File: rtl/display_router.sv
// Registered 7-segment router: picks one of NUM_SRC display triplets via a mode-to-source map,
// with a timed overlay and blanking when off. Define ROUTER_BLANK_EN to insert a blank gap on source changes.
module display_router #(
  parameter int NUM_SRC      = 8,
  parameter int MODE_W       = 3,
  parameter int HOLD_CYCLES  = 100000000,
  parameter int BLANK_CYCLES = 4,
  localparam int SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 machine_state,
  input  logic [MODE_W-1:0]    mode_state,
  input  logic [NUM_SRC*8-1:0] src_digit1,
  input  logic [NUM_SRC*8-1:0] src_digit2,
  input  logic [NUM_SRC*8-1:0] src_tube_sel,
  input  logic                 map_wr_en,
  input  logic [MODE_W-1:0]    map_wr_addr,
  input  logic [SRC_W-1:0]     map_wr_src,
  input  logic                 overlay_req,
  input  logic [SRC_W-1:0]     overlay_src,
  output logic [7:0]           digit1,
  output logic [7:0]           digit2,
  output logic [7:0]           tube_sel,
  output logic [SRC_W-1:0]     active_src,
  output logic                 overlay_active
);
  // state   | meaning
  // OFF     | machine off, outputs blanked
  // RUN     | driving map[mode_state]
  // OVERLAY | driving latched ovl_src until the hold counter expires
  // BLANK   | gap after a source change (ROUTER_BLANK_EN only)

  localparam int MAP_N = 1 << MODE_W;
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [SRC_W:0]   SRC_LIM = (SRC_W+1)'(NUM_SRC);
  localparam logic [CNT_W-1:0] HOLD_L  = CNT_W'(HOLD_CYCLES);

  if (HOLD_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_param_check
    $error("display_router: HOLD_CYCLES and BLANK_CYCLES must be at least 1");
  end

`ifdef ROUTER_BLANK_EN
  typedef enum logic [1:0] {OFF, RUN, OVERLAY, BLANK} state_t;
  localparam int BCNT_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [BCNT_W-1:0] BLANK_L = BCNT_W'(BLANK_CYCLES);
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
  logic [SRC_W-1:0]  cur_src;
`else
  typedef enum logic [1:0] {OFF, RUN, OVERLAY} state_t;
`endif

  state_t           state, state_nxt;
  logic [SRC_W-1:0] map [MAP_N];
  logic [SRC_W-1:0] ovl_src, ovl_src_nxt, tgt_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req_ok, wr_ok, ovl_nxt, show;

  assign req_ok = overlay_req && ({1'b0, overlay_src} < SRC_LIM);
  assign wr_ok  = map_wr_en && ({1'b0, map_wr_src} < SRC_LIM);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ovl_src_nxt = ovl_src;
    ovl_nxt     = 1'b0;
    show        = 1'b0;
    tgt_nxt     = map[mode_state];
`ifdef ROUTER_BLANK_EN
    bcnt_nxt    = bcnt;
`endif
    if (!machine_state) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
`ifdef ROUTER_BLANK_EN
      bcnt_nxt  = '0;
`endif
    end else if (state == OFF) begin
      state_nxt = RUN;
    end else begin
      // a retrigger wins over expiry and over a simultaneous mode change
      if (req_ok) begin
        cnt_nxt     = HOLD_L;
        ovl_src_nxt = overlay_src;
      end else if (cnt != '0) begin
        cnt_nxt = cnt - CNT_W'(1);
      end
      ovl_nxt   = (cnt_nxt != '0);
      if (ovl_nxt) tgt_nxt = ovl_src_nxt;
      state_nxt = ovl_nxt ? OVERLAY : RUN;
      show      = 1'b1;
`ifdef ROUTER_BLANK_EN
      if (tgt_nxt != cur_src) begin
        state_nxt = BLANK;
        bcnt_nxt  = BLANK_L;
        show      = 1'b0;
      end else if (state == BLANK) begin
        if (bcnt != BCNT_W'(1)) begin
          state_nxt = BLANK;
          bcnt_nxt  = bcnt - BCNT_W'(1);
          show      = 1'b0;
        end else begin
          bcnt_nxt = '0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= OFF;
      cnt            <= '0;
      ovl_src        <= '0;
      digit1         <= '0;
      digit2         <= '0;
      tube_sel       <= '0;
      active_src     <= '0;
      overlay_active <= 1'b0;
      for (int i = 0; i < MAP_N; i++) map[i] <= SRC_W'(i % NUM_SRC);
`ifdef ROUTER_BLANK_EN
      bcnt           <= '0;
      cur_src        <= '0;
`endif
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      ovl_src        <= ovl_src_nxt;
      overlay_active <= show && ovl_nxt;
      if (wr_ok) map[map_wr_addr] <= map_wr_src;
      if (show) begin
        digit1     <= src_digit1[8*tgt_nxt +: 8];
        digit2     <= src_digit2[8*tgt_nxt +: 8];
        tube_sel   <= src_tube_sel[8*tgt_nxt +: 8];
        active_src <= tgt_nxt;
      end else begin
        digit1     <= '0;
        digit2     <= '0;
        tube_sel   <= '0;
        active_src <= '0;
      end
`ifdef ROUTER_BLANK_EN
      bcnt           <= bcnt_nxt;
      cur_src        <= tgt_nxt;
`endif
    end
  end

endmodule
